// File: rtl/aes_pkg.sv
// Shared AES widths, SubBytes FSM encoding and the byte-to-bit-slice helper.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Byte 0 is the most significant byte: byte i lives at [127-8i -: 8].
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return 7'(AES_STATE_W - 8) - {idx, 3'b000};
    endfunction

endpackage

// File: rtl/aes_subbytes_serial_if.sv
// Upstream state handshake and downstream result handshake of the SubBytes stage.
interface aes_subbytes_serial_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_state;
    logic                   in_enc_dec;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_state;

    modport slave (
        input  in_valid, in_state, in_enc_dec, out_ready,
        output in_ready, out_valid, out_state
    );

    modport master (
        output in_valid, in_state, in_enc_dec, out_ready,
        input  in_ready, out_valid, out_state
    );

endinterface

// File: rtl/aes_sbox_composite_working.sv
// Combinational AES S-box / inverse S-box sharing one GF(2^8) inverter.
module aes_sbox_composite_working (
    input  logic       i_enc_dec,
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte_c
);

    function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] w_inv_in;
    logic [7:0] w_inv_out;
    logic [7:0] w_fwd;

    // Decrypt undoes the affine map before inversion; encrypt applies it after.
    always_comb begin
        w_inv_in  = i_enc_dec ? i_byte
                              : (rotl(i_byte, 1) ^ rotl(i_byte, 3) ^ rotl(i_byte, 6) ^ 8'h05);
        w_inv_out = gf_inv(w_inv_in);
        w_fwd     = w_inv_out ^ rotl(w_inv_out, 1) ^ rotl(w_inv_out, 2)
                  ^ rotl(w_inv_out, 3) ^ rotl(w_inv_out, 4) ^ 8'h63;
        o_byte_c  = i_enc_dec ? w_fwd : w_inv_out;
    end

endmodule

// File: rtl/aes_subbytes_serial.sv
// Iterative SubBytes/InvSubBytes: SBOX_LANES bytes per cycle over valid/ready.
// Define AES_SUBBYTES_PIPE_EN to register the S-box outputs (latency NCHUNK+1).
module aes_subbytes_serial
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_subbytes_serial_if.slave  bus
);

    localparam int unsigned NCHUNK = AES_BYTES / SBOX_LANES;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    if (!(SBOX_LANES inside {1, 2, 4, 8, 16})) begin : g_bad_lanes
        $error("aes_subbytes_serial: SBOX_LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_state_e             r_state;
    fsm_state_e             w_next;
    logic [AES_STATE_W-1:0] r_in_state;
    logic                   r_enc_dec;
    logic [AES_STATE_W-1:0] r_out_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   w_in_ready_nxt;
    logic                   w_out_valid_nxt;

    logic [7:0]             w_sbox_out [SBOX_LANES];
    logic [7:0]             w_wr_bytes [SBOX_LANES];
    logic [CNT_W-1:0]       w_wr_cnt;
    logic                   w_wr_en;
    logic                   w_last_wr;

    // Lane mux picks chunk r_cnt of the captured state for each S-box.
    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        logic [3:0] w_idx;
        logic [7:0] w_sbox_in;
        assign w_idx     = 4'(32'(r_cnt) * SBOX_LANES + l);
        assign w_sbox_in = r_in_state[byte_lsb(w_idx) +: 8];
        aes_sbox_composite_working u_sbox (
            .i_enc_dec (r_enc_dec),
            .i_byte    (w_sbox_in),
            .o_byte_c  (w_sbox_out[l])
        );
    end

`ifdef AES_SUBBYTES_PIPE_EN
    logic [7:0]       r_pipe [SBOX_LANES];
    logic [CNT_W-1:0] r_pipe_cnt;
    logic             r_pipe_vld;

    // Chunk selected in cycle j is written in cycle j+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe     <= '{default: '0};
            r_pipe_cnt <= '0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_pipe     <= w_sbox_out;
            r_pipe_cnt <= r_cnt;
            r_pipe_vld <= (r_state == BUSY) && (w_next == BUSY);
        end
    end

    assign w_wr_en    = r_pipe_vld;
    assign w_wr_cnt   = r_pipe_cnt;
    assign w_wr_bytes = r_pipe;
`else
    assign w_wr_en    = (r_state == BUSY);
    assign w_wr_cnt   = r_cnt;
    assign w_wr_bytes = w_sbox_out;
`endif

    assign w_last_wr = w_wr_en && (w_wr_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid && r_in_ready) w_next = BUSY;
            BUSY:    if (w_last_wr)                  w_next = DONE;
            DONE:    if (bus.out_ready)              w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        case (w_next)
            IDLE:    w_in_ready_nxt  = 1'b1;
            DONE:    w_out_valid_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Capture on accept, step the chunk counter, merge substituted bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_state  <= '0;
            r_enc_dec   <= 1'b0;
            r_cnt       <= '0;
            r_out_state <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_next == BUSY) begin
                        r_in_state <= bus.in_state;
                        r_enc_dec  <= bus.in_enc_dec;
                        r_cnt      <= '0;
                    end
                end
                BUSY:    r_cnt <= ((w_next == DONE) || (r_cnt == LAST)) ? '0 : r_cnt + CNT_W'(1);
                default: ;
            endcase
            if (w_wr_en) begin
                for (int unsigned l = 0; l < SBOX_LANES; l++) begin
                    r_out_state[byte_lsb(4'(32'(w_wr_cnt) * SBOX_LANES + l)) +: 8] <= w_wr_bytes[l];
                end
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_out_state;

endmodule

// File: tb/tb_aes_subbytes_serial.sv
// Scoreboard bench: directed checks on a 4-lane instance plus random sweeps of 1/2/8/16 lanes.
module tb_aes_subbytes_serial;

`ifdef AES_SUBBYTES_PIPE_EN
    localparam int unsigned PIPE = 1;
`else
    localparam int unsigned PIPE = 0;
`endif
    localparam int unsigned NDUT  = 5;
    localparam int          NRAND = 256;

    function automatic int unsigned lanes_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   sweep_go = 1'b0;
    bit   sweep_done [NDUT];

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] exp_q   [NDUT][$];
    int           acc_q   [NDUT][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_subbytes_serial_if u_if [NDUT] ();

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic enc);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = enc ? sbox_t[b] : isbox_t[b];
        end
        return r;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_lane
        localparam int unsigned L   = lanes_of(g);
        localparam int unsigned LAT = 16 / L + PIPE;

        aes_subbytes_serial #(.SBOX_LANES(L)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (u_if[g])
        );

        // Monitor: log accept edges, compare data and latency on each out_valid rise.
        logic prev_ov = 1'b0;
        always @(negedge clk) begin
            int a;
            if (rst) begin
                acc_q[g].delete();
                prev_ov = 1'b0;
            end else begin
                if (u_if[g].in_valid && u_if[g].in_ready) acc_q[g].push_back(cyc + 1);
                if (u_if[g].out_valid && !prev_ov) begin
                    if (exp_q[g].size() == 0 || acc_q[g].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL lane%0d unexpected output: got %h expected none", L, u_if[g].out_state);
                    end else begin
                        check($sformatf("lane%0d data", L), u_if[g].out_state, exp_q[g].pop_front());
                        a = acc_q[g].pop_front();
                        check($sformatf("lane%0d latency", L), 128'(cyc - a), 128'(LAT));
                    end
                end
                prev_ov = u_if[g].out_valid;
            end
        end

        if (g != 0) begin : g_drv
            always @(negedge clk) u_if[g].out_ready = sweep_go ? ($urandom_range(0, 3) != 0) : 1'b1;

            initial begin
                logic [127:0] st;
                logic         enc;
                int           t;
                u_if[g].in_valid   = 1'b0;
                u_if[g].in_state   = '0;
                u_if[g].in_enc_dec = 1'b0;
                wait (sweep_go);
                for (int n = 0; n < NRAND; n++) begin
                    st  = {$urandom, $urandom, $urandom, $urandom};
                    enc = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    u_if[g].in_valid   = 1'b1;
                    u_if[g].in_state   = st;
                    u_if[g].in_enc_dec = enc;
                    exp_q[g].push_back(ref_sub(st, enc));
                    t = 0;
                    while (!u_if[g].in_ready && t < 200) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 200) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL lane%0d accept timeout: got in_ready=0 expected 1", L);
                    end
                    @(posedge clk);
                    #1 u_if[g].in_valid = 1'b0;
                end
                t = 0;
                while (exp_q[g].size() != 0 && t < 2000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 2000) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL lane%0d drain timeout: got %0d pending expected 0", L, exp_q[g].size());
                end
                sweep_done[g] = 1'b1;
            end
        end
    end

    task automatic send0(input logic [127:0] st, input logic enc, input bit push, input logic [127:0] expv);
        int t;
        @(negedge clk);
        u_if[0].in_valid   = 1'b1;
        u_if[0].in_state   = st;
        u_if[0].in_enc_dec = enc;
        if (push) exp_q[0].push_back(expv);
        t = 0;
        while (!u_if[0].in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL send timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1 u_if[0].in_valid = 1'b0;
    endtask

    task automatic drain0();
        int t;
        t = 0;
        while (exp_q[0].size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain timeout: got %0d pending expected 0", exp_q[0].size());
        end
    endtask

    initial begin
        logic [7:0] p, q, x;
        bit         all_done;
        int         t;

        // Reference tables from the generator walk, independent of the RTL's algebra.
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);

        u_if[0].in_valid   = 1'b0;
        u_if[0].in_state   = '0;
        u_if[0].in_enc_dec = 1'b0;
        u_if[0].out_ready  = 1'b1;

        // Reset
        repeat (3) @(negedge clk);
        check("reset out_valid", 128'(u_if[0].out_valid), 128'(0));
        check("reset out_state", u_if[0].out_state, 128'h0);
        check("reset in_ready", 128'(u_if[0].in_ready), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 128'(u_if[0].in_ready), 128'(1));

        // Encrypt then decrypt round trip
        send0(128'h00112233445566778899aabbccddeeff, 1'b1, 1'b1, 128'h638293c31bfc33f5c4eeacea4bc12816);
        drain0();
        send0(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0, 1'b1, 128'h00112233445566778899aabbccddeeff);
        drain0();

        // Backpressure in DONE
        @(negedge clk);
        u_if[0].out_ready = 1'b0;
        send0({16{8'h01}}, 1'b1, 1'b1, {16{8'h7c}});
        t = 0;
        while (!u_if[0].out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("bp out_valid rise", 128'(u_if[0].out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            u_if[0].in_valid   = 1'b1;
            u_if[0].in_state   = {$urandom, $urandom, $urandom, $urandom};
            u_if[0].in_enc_dec = 1'b1;
            check("bp out_state hold", u_if[0].out_state, {16{8'h7c}});
            check("bp in_ready low", 128'(u_if[0].in_ready), 128'(0));
            check("bp out_valid held", 128'(u_if[0].out_valid), 128'(1));
        end
        @(negedge clk);
        u_if[0].in_valid  = 1'b0;
        u_if[0].out_ready = 1'b1;
        @(negedge clk);
        check("bp release out_valid", 128'(u_if[0].out_valid), 128'(0));
        check("bp release in_ready", 128'(u_if[0].in_ready), 128'(1));
        check("bp release out_state kept", u_if[0].out_state, {16{8'h7c}});

        // Reset while BUSY discards the work
        send0(128'h0123456789abcdeffedcba9876543210, 1'b1, 1'b0, '0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("busy-reset out_valid", 128'(u_if[0].out_valid), 128'(0));
        check("busy-reset out_state", u_if[0].out_state, 128'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("busy-reset no output", 128'(u_if[0].out_valid), 128'(0));
        send0(128'h0, 1'b1, 1'b1, {16{8'h63}});
        drain0();

        // Random sweeps over the other lane counts
        sweep_go = 1'b1;
        t = 0;
        all_done = 1'b0;
        while (!all_done && t < 40000) begin
            @(negedge clk);
            t++;
            all_done = 1'b1;
            for (int g = 1; g < NDUT; g++) if (!sweep_done[g]) all_done = 1'b0;
        end
        if (!all_done) begin
            n_cmp++;
            n_err++;
            $display("FAIL sweep timeout: got incomplete expected all lanes done");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
